sram_port_arbiter: RTL and testbench

- Shares one single-ported, 1-cycle-read-latency unified SRAM between the instruction-fetch requester and the data (load/store) requester.
- Grants at most one request per cycle. Records the owner of each read and routes the returned data back to that owner one cycle later.
- A streak counter prevents the instruction side from being starved by back-to-back data accesses.
- Sits between the IF/MEM stage SRAM interfaces and the physical SRAM.

---
 rtl/sram_arbiter_params.sv | 14 +
 rtl/sram_arbiter_priority.sv | 23 ++
 rtl/sram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_params.sv
// Shared types for the unified-SRAM arbiter: return-owner tag, streak counter, default streak limit.
package sram_arbiter_params;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        INST      = 2'd1,
        DATA_READ = 2'd2
    } ReturnOwner;

    typedef logic [3:0] StreakCount;

    localparam int DEFAULT_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/sram_arbiter_priority.sv
// Combinational grant decision: data wins a conflict unless its streak has hit the limit.
// Zero latency; a losing requester simply sees no grant and keeps requesting.
module sram_arbiter_priority
    import sram_arbiter_params::*;
#(
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic       inst_request,
    input  logic       data_request,
    input  StreakCount streak,
    output logic       inst_grant,
    output logic       data_grant
);

    localparam StreakCount MAX_STREAK = StreakCount'(MAX_DATA_STREAK);

    logic inst_forced;

    assign inst_forced = (streak == MAX_STREAK);
    assign inst_grant  = inst_request && (!data_request || inst_forced);
    assign data_grant  = data_request && !inst_grant;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency SRAM between inst and data sides; grants same cycle, read data returns next cycle.
// No buffering: the ungranted side holds its request. `SRAM_ARB_PERF_COUNTER_EN adds grant/conflict counters.
module sram_port_arbiter
    import sram_arbiter_params::*;
#(
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inst_request,
    input  logic [ADDRESS_WIDTH-1:0]  inst_address,
    output logic                      inst_grant,
    output logic                      inst_read_valid,
    output logic [DATA_WIDTH-1:0]     inst_read_data,
    input  logic                      data_request,
    input  logic [DATA_WIDTH/8-1:0]   data_write_strobe,
    input  logic [ADDRESS_WIDTH-1:0]  data_address,
    input  logic [DATA_WIDTH-1:0]     data_write_data,
    output logic                      data_grant,
    output logic                      data_read_valid,
    output logic [DATA_WIDTH-1:0]     data_read_data,
    output logic                      ram_enabled,
    output logic [DATA_WIDTH/8-1:0]   ram_write_strobe,
    output logic [ADDRESS_WIDTH-1:0]  ram_address,
    output logic [DATA_WIDTH-1:0]     ram_write_data,
    input  logic [DATA_WIDTH-1:0]     ram_read_data
`ifdef SRAM_ARB_PERF_COUNTER_EN
    ,
    output logic [31:0]               inst_grant_count,
    output logic [31:0]               data_grant_count,
    output logic [31:0]               conflict_count
`endif
);

    localparam StreakCount MAX_STREAK = StreakCount'(MAX_DATA_STREAK);

    logic       raw_inst_grant;
    logic       raw_data_grant;
    StreakCount streak_q, streak_d;
    ReturnOwner owner_q, owner_d;

    sram_arbiter_priority #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_priority (
        .inst_request (inst_request),
        .data_request (data_request),
        .streak       (streak_q),
        .inst_grant   (raw_inst_grant),
        .data_grant   (raw_data_grant)
    );

    // Grants must fall the instant reset asserts, not at the next edge.
    assign inst_grant  = reset & raw_inst_grant;
    assign data_grant  = reset & raw_data_grant;
    assign ram_enabled = inst_grant | data_grant;

    always_comb begin
        ram_address      = '0;
        ram_write_strobe = '0;
        ram_write_data   = '0;
        if (inst_grant) begin
            ram_address = inst_address;
        end else if (data_grant) begin
            ram_address      = data_address;
            ram_write_strobe = data_write_strobe;
            ram_write_data   = data_write_data;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (inst_grant || !inst_request) begin
            streak_d = '0;
        end else if (data_grant && (streak_q != MAX_STREAK)) begin
            streak_d = streak_q + StreakCount'(1);
        end
    end

    always_comb begin
        owner_d = NONE;
        if (inst_grant) begin
            owner_d = INST;
        end else if (data_grant && (data_write_strobe == '0)) begin
            owner_d = DATA_READ;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
            owner_q  <= NONE;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    assign inst_read_valid = (owner_q == INST);
    assign data_read_valid = (owner_q == DATA_READ);
    assign inst_read_data  = ram_read_data;
    assign data_read_data  = ram_read_data;

`ifdef SRAM_ARB_PERF_COUNTER_EN
    logic [31:0] inst_cnt_q;
    logic [31:0] data_cnt_q;
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inst_cnt_q     <= '0;
            data_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (inst_grant)                   inst_cnt_q     <= inst_cnt_q + 32'd1;
            if (data_grant)                   data_cnt_q     <= data_cnt_q + 32'd1;
            if (inst_request && data_request) conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign inst_grant_count = inst_cnt_q;
    assign data_grant_count = data_cnt_q;
    assign conflict_count   = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and random bench for sram_port_arbiter with an SRAM model and a rule-level reference model.
module tb_sram_port_arbiter;

    localparam int MAXS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inst_request = 1'b0;
    logic [31:0] inst_address = '0;
    logic        inst_grant, inst_read_valid;
    logic [31:0] inst_read_data;
    logic        data_request = 1'b0;
    logic [3:0]  data_write_strobe = '0;
    logic [31:0] data_address = '0;
    logic [31:0] data_write_data = '0;
    logic        data_grant, data_read_valid;
    logic [31:0] data_read_data;
    logic        ram_enabled;
    logic [3:0]  ram_write_strobe;
    logic [31:0] ram_address, ram_write_data;
    logic [31:0] ram_read_data = '0;
`ifdef SRAM_ARB_PERF_COUNTER_EN
    logic [31:0] inst_grant_count, data_grant_count, conflict_count;
`endif

    sram_port_arbiter #(
        .MAX_DATA_STREAK (MAXS),
        .ADDRESS_WIDTH   (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .inst_request      (inst_request),
        .inst_address      (inst_address),
        .inst_grant        (inst_grant),
        .inst_read_valid   (inst_read_valid),
        .inst_read_data    (inst_read_data),
        .data_request      (data_request),
        .data_write_strobe (data_write_strobe),
        .data_address      (data_address),
        .data_write_data   (data_write_data),
        .data_grant        (data_grant),
        .data_read_valid   (data_read_valid),
        .data_read_data    (data_read_data),
        .ram_enabled       (ram_enabled),
        .ram_write_strobe  (ram_write_strobe),
        .ram_address       (ram_address),
        .ram_write_data    (ram_write_data),
        .ram_read_data     (ram_read_data)
`ifdef SRAM_ARB_PERF_COUNTER_EN
        ,
        .inst_grant_count  (inst_grant_count),
        .data_grant_count  (data_grant_count),
        .conflict_count    (conflict_count)
`endif
    );

    always #5 clock = ~clock;

    int cmp_count  = 0;
    int fail_count = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'hc3a5_5a3c;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Physical SRAM model
    logic [31:0] sram_mem [logic [31:0]];
    always @(posedge clock) begin
        if (ram_enabled) begin
            logic [31:0] w;
            w = sram_mem.exists(ram_address) ? sram_mem[ram_address] : init_word(ram_address);
            if (ram_write_strobe == 4'h0) ram_read_data <= w;
            else sram_mem[ram_address] = merge(w, ram_write_data, ram_write_strobe);
        end
    end

    // Reference model state: memory contents, streak, and who expects data next cycle
    logic [31:0] ref_mem [logic [31:0]];
    int          m_streak = 0;
    int          m_owner  = 0;   // 0 none, 1 inst, 2 data read
    logic [31:0] m_data   = '0;
    logic        dut_ig_seen;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        cmp_count++;
        assert (obs === exp_v) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle with reset released: drive, check mid-cycle, advance the model at the edge.
    task automatic run_cycle(input logic ireq, input logic [31:0] iaddr,
                             input logic dreq, input logic [3:0] dstrb,
                             input logic [31:0] daddr, input logic [31:0] dwd,
                             output logic ig_o, output logic dg_o);
        logic eig, edg;
        inst_request = ireq; inst_address = iaddr;
        data_request = dreq; data_write_strobe = dstrb;
        data_address = daddr; data_write_data = dwd;
        @(negedge clock);
        if (ireq && dreq) eig = (m_streak == MAXS);
        else              eig = ireq;
        edg = dreq && !eig;
        dut_ig_seen = inst_grant;
        chk("inst_grant", {31'd0, inst_grant}, {31'd0, eig});
        chk("data_grant", {31'd0, data_grant}, {31'd0, edg});
        chk("ram_enabled", {31'd0, ram_enabled}, {31'd0, eig | edg});
        chk("ram_address", ram_address, eig ? iaddr : (edg ? daddr : 32'd0));
        chk("ram_strobe", {28'd0, ram_write_strobe}, {28'd0, edg ? dstrb : 4'h0});
        if (eig || edg) chk("ram_wdata", ram_write_data, edg ? dwd : 32'd0);
        chk("inst_read_valid", {31'd0, inst_read_valid}, {31'd0, m_owner == 1});
        chk("data_read_valid", {31'd0, data_read_valid}, {31'd0, m_owner == 2});
        if (m_owner == 1) chk("inst_read_data", inst_read_data, m_data);
        if (m_owner == 2) chk("data_read_data", data_read_data, m_data);
        @(posedge clock);
        if (eig)      m_data = ref_rd(iaddr);
        else if (edg) m_data = ref_rd(daddr);
        if (edg && dstrb != 4'h0) ref_mem[daddr] = merge(ref_rd(daddr), dwd, dstrb);
        m_owner  = eig ? 1 : ((edg && dstrb == 4'h0) ? 2 : 0);
        if (eig || !ireq)  m_streak = 0;
        else if (edg)      m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        #1;
        ig_o = eig;
        dg_o = edg;
    endtask

    initial begin
        logic        gi, gd, ip, dp;
        logic [31:0] ia, da, dw;
        logic [3:0]  ds;
        logic [9:0]  pat, exp_pat;
`ifdef SRAM_ARB_PERF_COUNTER_EN
        logic [31:0] c_i0, c_d0, c_c0;
`endif

        // Reset state with both sides requesting
        inst_request = 1'b1; data_request = 1'b1; inst_address = 32'h40; data_address = 32'h80;
        @(negedge clock);
        chk("rst_inst_grant", {31'd0, inst_grant}, 32'd0);
        chk("rst_data_grant", {31'd0, data_grant}, 32'd0);
        chk("rst_ram_enabled", {31'd0, ram_enabled}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_read_valid}, 32'd0);
        chk("rst_data_valid", {31'd0, data_read_valid}, 32'd0);
        inst_request = 1'b0; data_request = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Reset asserted while an inst read is in flight
        inst_request = 1'b1; inst_address = 32'hbfc00000;
        @(negedge clock);
        chk("midrd_grant", {31'd0, inst_grant}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrd_rst_grant", {31'd0, inst_grant | data_grant}, 32'd0);
        chk("midrd_rst_ram_en", {31'd0, ram_enabled}, 32'd0);
        @(posedge clock); #1;
        chk("midrd_valid", {31'd0, inst_read_valid}, 32'd0);
        inst_request = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_owner = 0; m_streak = 0;
        @(posedge clock); #1;
        run_cycle(0, 0, 0, 0, 0, 0, gi, gd);

        // Inst-only fetch, then response
        run_cycle(1, 32'hbfc00004, 0, 0, 0, 0, gi, gd);
        run_cycle(0, 0, 0, 0, 0, 0, gi, gd);

        // Store with no inst request, then read it back
        run_cycle(0, 0, 1, 4'hf, 32'h1000, 32'hdeadbeef, gi, gd);
        run_cycle(0, 0, 1, 4'h0, 32'h1000, 0, gi, gd);
        run_cycle(0, 0, 0, 0, 0, 0, gi, gd);
        chk("store_readback", m_data, 32'hdeadbeef);

        // Continuous conflict: D,D,D,D,I repeating
`ifdef SRAM_ARB_PERF_COUNTER_EN
        c_i0 = inst_grant_count; c_d0 = data_grant_count; c_c0 = conflict_count;
`endif
        exp_pat = 10'b00001_00001;
        for (int k = 0; k < 10; k++) begin
            run_cycle(1, 32'h300, 1, 4'h0, 32'h400, 0, gi, gd);
            pat[9-k] = dut_ig_seen;
        end
        chk("streak_pattern", {22'd0, pat}, {22'd0, exp_pat});
`ifdef SRAM_ARB_PERF_COUNTER_EN
        chk("perf_conflict", conflict_count - c_c0, 32'd10);
        chk("perf_inst", inst_grant_count - c_i0, 32'd2);
        chk("perf_data", data_grant_count - c_d0, 32'd8);
`endif
        run_cycle(0, 0, 0, 0, 0, 0, gi, gd);

        // Data read then inst read on consecutive cycles
        run_cycle(0, 0, 1, 4'h0, 32'h2000, 0, gi, gd);
        run_cycle(1, 32'h2004, 0, 0, 0, 0, gi, gd);
        run_cycle(0, 0, 0, 0, 0, 0, gi, gd);

        // Random traffic; each side holds its request until granted
        ip = 0; dp = 0; ia = 0; da = 0; dw = 0; ds = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1;
                ia = 32'h100 + (32'($urandom_range(0, 15)) << 2);
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1;
                da = 32'h100 + (32'($urandom_range(0, 15)) << 2);
                dw = $urandom;
                ds = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            run_cycle(ip, ia, dp, ds, da, dw, gi, gd);
            if (gi) ip = 0;
            if (gd) dp = 0;
        end
        run_cycle(0, 0, 0, 0, 0, 0, gi, gd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
